cordic_gravity_vec: RTL
=======================

Name: cordic_gravity_vec

Overview:
- Inverse of the accelerometer tilt path: takes pitch, roll and a gravity magnitude, and produces the expected body-frame gravity vector (ax, ay, az).
- Used by the attitude loop to cross-check the tilt estimate against raw accelerometer data, and by the test harness to synthesise accelerometer stimulus from known angles.
- A single iterative rotation-mode CORDIC core is time-multiplexed over two passes: pitch first, then roll. No general multipliers; only one constant gain multiply.

Parameters:
- ITERATIONS, 12, CORDIC micro-rotations per pass; legal range 8..16.
- DW, 20, internal x/y datapath width (16 + 4 guard bits).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  level request; sampled in IDLE
- pitch_in  input  16  signed angle; 32768 LSB = 180 deg
- roll_in  input  16  signed angle, same units
- g_in  input  16  signed gravity magnitude in accel LSB (1 g = 16384)
- busy  output  1  high from the cycle after start is accepted until the DONE state is entered
- done  output  1  result valid; held until start is released
- range_err  output  1  an angle was clamped; valid while done is high
- ax  output  16  signed, g·sin(pitch)
- ay  output  16  signed, g·cos(pitch)·sin(roll)
- az  output  16  signed, g·cos(pitch)·cos(roll)

Behaviour:
- Reset: all outputs = 0; state = IDLE; internal x/y/z and iteration counter = 0. Reset asserted mid-operation aborts immediately; the next start after release runs cleanly.
- Angle clamp: applied at capture. Each angle is clamped to [-16384, +16384] (±90 deg, inside CORDIC convergence). range_err = 1 if either angle was clamped.
- Gain compensation:
  - Each pass starts with x0 = (v · 19898) >>> 15, where 19898 is 1/K in Q15 and v is the pass input. y0 = 0.
  - Product is a 32-bit signed intermediate; the shift is arithmetic.
- Micro-rotation i, i = 0..ITERATIONS-1:
  - d = (z >= 0) ? +1 : -1.
  - x' = x - d·(y >>> i); y' = y + d·(x >>> i); z' = z - d·atan_tab[i].
- atan_tab, angle units, i = 0..15: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- States:
  - IDLE: done = 0, busy = 0. If start: capture clamped angles, g_in and range_err; go to LOAD1.
  - LOAD1: x = scaled g, y = 0, z = pitch; counter = 0; go to ROT1.
  - ROT1: one micro-rotation per cycle; after ITERATIONS cycles go to LOAD2.
  - LOAD2: ax_reg = sat16(y); x = scaled current x (g·cos p); y = 0; z = roll; counter = 0; go to ROT2.
  - ROT2: ITERATIONS cycles; then go to OUT.
  - OUT: ay = sat16(y), az = sat16(x), ax = ax_reg; done = 1; go to DONE.
  - DONE: outputs and done held. When start = 0: done = 0, go to IDLE. ax/ay/az/range_err keep their values until the next OUT.
- Latency: done rises on clock edge 2·ITERATIONS+3 counted after the edge that sampled start (27 for the default).
- Input handling: inputs are sampled only in IDLE. Changes to inputs or start during LOAD/ROT are ignored. start held high continuously yields exactly one computation per start assertion.
- Saturation: sat16 clamps to [-32768, 32767]. It is only reachable with g_in = -32768.
- Negative g_in: the vector is negated and no error is flagged.
- Accuracy: |error| ≤ 8 LSB per component for |g_in| ≤ 16384 at ITERATIONS = 12.

Test Plan:
- g=16384, pitch=0, roll=0, start pulse → done at edge 27; ax≈0, ay≈0, az≈16384 (±8); busy high during computation; range_err=0.
- g=16384, pitch=8192 (45 deg), roll=0 → ax≈11585, ay≈0, az≈11585 (±8).
- g=16384, pitch=0, roll=5461 (30 deg) → ax≈0, ay≈8192, az≈14189; repeat with roll=-5461 → ay≈-8192.
- g=16384, pitch=20000, roll=0 → pitch clamped to 16384; ax≈16384, az≈0 (±8); range_err=1.
- Hold start high for 40 cycles → exactly one done assertion, done held until start falls, then done=0 next cycle; outputs retain values in IDLE.
- Assert rst_n=0 at ROT1 cycle 5 → all outputs 0 at once; after release, a new start with pitch=-8192 gives ax≈-11585, az≈11585.

Source files
------------

// File: rtl/cordic_gravity_vec.sv
// rtl/cordic_gravity_vec.sv - two-pass rotation-mode CORDIC turning pitch/roll/|g| into a body-frame gravity vector
// Pass 1 rotates (g/K, 0) by pitch; pass 2 rotates (x1/K, 0) by roll, reusing the same core and gain multiply.
module cordic_gravity_vec #(
  parameter int ITERATIONS = 12,
  parameter int DW         = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] pitch_in,
  input  logic [15:0] roll_in,
  input  logic [15:0] g_in,
  output logic        busy,
  output logic        done,
  output logic        range_err,
  output logic [15:0] ax,
  output logic [15:0] ay,
  output logic [15:0] az
);

  localparam int ZW = 18;
  localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);
  localparam logic signed [DW-1:0] SAT_MAX = DW'(32767);
  localparam logic signed [DW-1:0] SAT_MIN = DW'(-32768);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD1, S_ROT1, S_LOAD2, S_ROT2, S_OUT, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic signed [DW-1:0] r_x, r_y;
  logic signed [ZW-1:0] r_z, r_pitch, r_roll;
  logic [3:0]           r_cnt;
  logic [15:0]          r_g, r_ax;
  logic                 r_err;

  logic signed [31:0]   w_gain_in, w_prod;
  logic signed [DW-1:0] w_scaled, w_xs, w_ys, w_x_rot, w_y_rot;
  logic signed [ZW-1:0] w_atan, w_z_rot;
  logic                 w_d_pos;

  // Angles beyond +/-90 deg would leave the CORDIC convergence range.
  function automatic logic signed [ZW-1:0] clamp_ang(input logic [15:0] a);
    logic signed [15:0] s;
    s = $signed(a);
    if (s > 16'sd16384)       return ZW'(16384);
    else if (s < -16'sd16384) return ZW'(-16384);
    else                      return ZW'(s);
  endfunction

  function automatic logic over_range(input logic [15:0] a);
    logic signed [15:0] s;
    s = $signed(a);
    return (s > 16'sd16384) || (s < -16'sd16384);
  endfunction

  function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    return ZW'(8192);
      4'd1:    return ZW'(4836);
      4'd2:    return ZW'(2555);
      4'd3:    return ZW'(1297);
      4'd4:    return ZW'(651);
      4'd5:    return ZW'(326);
      4'd6:    return ZW'(163);
      4'd7:    return ZW'(81);
      4'd8:    return ZW'(41);
      4'd9:    return ZW'(20);
      4'd10:   return ZW'(10);
      4'd11:   return ZW'(5);
      4'd12:   return ZW'(3);
      4'd13:   return ZW'(1);
      4'd14:   return ZW'(1);
      default: return ZW'(0);
    endcase
  endfunction

  function automatic logic [15:0] sat16(input logic signed [DW-1:0] v);
    if (v > SAT_MAX)      return 16'h7fff;
    else if (v < SAT_MIN) return 16'h8000;
    else                  return v[15:0];
  endfunction

  // Single 1/K multiply shared by both load states.
  assign w_gain_in = (r_state == S_LOAD1) ? 32'($signed(r_g)) : 32'(r_x);
  assign w_prod    = w_gain_in * 32'sd19898;
  assign w_scaled  = DW'(w_prod >>> 15);

  assign w_xs    = r_x >>> r_cnt;
  assign w_ys    = r_y >>> r_cnt;
  assign w_atan  = atan_lut(r_cnt);
  assign w_d_pos = ~r_z[ZW-1];
  assign w_x_rot = w_d_pos ? (r_x - w_ys) : (r_x + w_ys);
  assign w_y_rot = w_d_pos ? (r_y + w_xs) : (r_y - w_xs);
  assign w_z_rot = w_d_pos ? (r_z - w_atan) : (r_z + w_atan);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD1;
      S_LOAD1: begin busy = 1'b1; w_next = S_ROT1; end
      S_ROT1:  begin busy = 1'b1; if (r_cnt == LAST_ITER) w_next = S_LOAD2; end
      S_LOAD2: begin busy = 1'b1; w_next = S_ROT2; end
      S_ROT2:  begin busy = 1'b1; if (r_cnt == LAST_ITER) w_next = S_OUT; end
      S_OUT:   begin busy = 1'b1; w_next = S_DONE; end
      S_DONE:  begin done = 1'b1; if (!start) w_next = S_IDLE; end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_cnt     <= '0;
      r_pitch   <= '0;
      r_roll    <= '0;
      r_g       <= '0;
      r_err     <= 1'b0;
      r_ax      <= '0;
      ax        <= '0;
      ay        <= '0;
      az        <= '0;
      range_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_pitch <= clamp_ang(pitch_in);
          r_roll  <= clamp_ang(roll_in);
          r_g     <= g_in;
          r_err   <= over_range(pitch_in) | over_range(roll_in);
        end
        S_LOAD1: begin
          r_x   <= w_scaled;
          r_y   <= '0;
          r_z   <= r_pitch;
          r_cnt <= '0;
        end
        S_ROT1, S_ROT2: begin
          r_x   <= w_x_rot;
          r_y   <= w_y_rot;
          r_z   <= w_z_rot;
          r_cnt <= r_cnt + 4'd1;
        end
        // x now holds g*cos(pitch); it becomes the magnitude for the roll pass.
        S_LOAD2: begin
          r_ax  <= sat16(r_y);
          r_x   <= w_scaled;
          r_y   <= '0;
          r_z   <= r_roll;
          r_cnt <= '0;
        end
        S_OUT: begin
          ax        <= r_ax;
          ay        <= sat16(r_y);
          az        <= sat16(r_x);
          range_err <= r_err;
        end
        default: ;
      endcase
    end
  end

endmodule
